// File: rtl/alu_issue.sv
// Issue stage in front of a registered ALU: one op in flight at a time.
// Reads the register file, drives the ALU, then writes the result back and strobes wb_valid.
module alu_issue #(
  parameter int NREGS = 16,
  parameter int RAW   = 4,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_fn,
  input  logic [RAW-1:0]  in_rd,
  input  logic [RAW-1:0]  in_rs1,
  input  logic [RAW-1:0]  in_rs2,
  input  logic            in_use_imm,
  input  logic [XLEN-1:0] in_imm,
  output logic            alu_en,
  output logic [3:0]      alu_fn,
  output logic [XLEN-1:0] alu_src1,
  output logic [XLEN-1:0] alu_src2,
  input  logic [XLEN-1:0] alu_res,
  output logic            wb_valid,
  output logic [RAW-1:0]  wb_rd,
  output logic [XLEN-1:0] wb_data,
  input  logic [RAW-1:0]  dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t          state;
  logic [XLEN-1:0] regs [NREGS];
  logic [RAW-1:0]  rd_p0;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;

  // r0 is hardwired to zero on every read path.
  assign rs1_val  = (in_rs1 == '0)   ? '0 : regs[in_rs1];
  assign rs2_val  = (in_rs2 == '0)   ? '0 : regs[in_rs2];
  assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];
  assign in_ready = !rst && (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      alu_en   <= 1'b0;
      alu_fn   <= '0;
      alu_src1 <= '0;
      alu_src2 <= '0;
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      rd_p0    <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      wb_valid <= 1'b0;
      case (state)
        // p0: accept and read operands
        IDLE: begin
          if (in_valid) begin
            alu_fn   <= in_fn;
            alu_src1 <= rs1_val;
            alu_src2 <= in_use_imm ? in_imm : rs2_val;
            alu_en   <= 1'b1;
            rd_p0    <= in_rd;
            state    <= ISSUE;
          end
        end
        // p1: ALU captures its operands on this edge
        ISSUE: begin
          alu_en <= 1'b0;
          state  <= WAIT;
        end
        // p2: ALU result is valid, write back
        WAIT: begin
          if (rd_p0 != '0) regs[rd_p0] <= alu_res;
          wb_valid <= 1'b1;
          wb_rd    <= rd_p0;
          wb_data  <= alu_res;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
